dsp_chain_sched: RTL and testbench

- Responder and controller end of the DSP-block handshake. It drives `start`, waits for `finish` and collects `y` from each effect block (lowpass_2-style clients).
- It owns the single shared multiplier/divider bus. It grants that bus to one client at a time and muxes the granted client's `mult_a`/`mult_b`/`div_n`/`div_d` onto it.
- It chains N clients in series once per audio sample: each client's `y` becomes the next client's `x`.
- It sits between the 48 kHz sample source and the shared_mult/shared_div instances.

---
 rtl/dsp_pkg.sv | 15 +
 rtl/dsp_bus_mux.sv | 34 +++
 rtl/dsp_chain_sched.sv | 147 ++++++++++++++
 tb/tb_dsp_chain_sched.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/dsp_pkg.sv
// Shared types and constants for the DSP effect-chain scheduler and its bus mux.
package dsp_pkg;

    localparam int SAMPLE_W       = 32;
    localparam int DIV_W          = 48;
    localparam int SAMPLE_RATE_HZ = 48000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GAP,
        ST_RUN,
        ST_DONE
    } state_e;

endpackage

// File: rtl/dsp_bus_mux.sv
// N-way mux of the shared multiplier/divider operands; drives zero unless a client holds the grant.
module dsp_bus_mux
    import dsp_pkg::*;
#(
    parameter int N_CLIENTS = 4,
    parameter int IDXW      = 3
) (
    input  logic                          grant_i,
    input  logic [IDXW-1:0]               idx_i,
    input  logic [N_CLIENTS*SAMPLE_W-1:0] mult_a_i,
    input  logic [N_CLIENTS*SAMPLE_W-1:0] mult_b_i,
    input  logic [N_CLIENTS*DIV_W-1:0]    div_n_i,
    input  logic [N_CLIENTS*DIV_W-1:0]    div_d_i,
    output logic [SAMPLE_W-1:0]           mult_a_o,
    output logic [SAMPLE_W-1:0]           mult_b_o,
    output logic [DIV_W-1:0]              div_n_o,
    output logic [DIV_W-1:0]              div_d_o
);

    always_comb begin
        // NOTE: every output gets a default first so no path through this block infers a latch.
        mult_a_o = '0;
        mult_b_o = '0;
        div_n_o  = '0;
        div_d_o  = '0;
        if (grant_i && int'(idx_i) < N_CLIENTS) begin
            mult_a_o = mult_a_i[int'(idx_i)*SAMPLE_W +: SAMPLE_W];
            mult_b_o = mult_b_i[int'(idx_i)*SAMPLE_W +: SAMPLE_W];
            div_n_o  = div_n_i[int'(idx_i)*DIV_W +: DIV_W];
            div_d_o  = div_d_i[int'(idx_i)*DIV_W +: DIV_W];
        end
    end

endmodule

// File: rtl/dsp_chain_sched.sv
// Runs one sample through a chain of DSP clients, granting the shared mult/div bus to one client at a time.
module dsp_chain_sched
    import dsp_pkg::*;
#(
    parameter int N_CLIENTS = 4,
    parameter int TIMEOUT   = 4000,
    parameter int IDXW      = 3
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          sample_tick,
    input  logic [SAMPLE_W-1:0]           x_in,
    input  logic [N_CLIENTS-1:0]          enable,
    output logic [SAMPLE_W-1:0]           y_out,
    output logic                          y_valid,
    output logic                          busy,
    output logic                          overrun,
    output logic                          fault,
    output logic [N_CLIENTS-1:0]          client_start,
    input  logic [N_CLIENTS-1:0]          client_finish,
    output logic [SAMPLE_W-1:0]           client_x,
    input  logic [N_CLIENTS*SAMPLE_W-1:0] client_y,
    input  logic [N_CLIENTS*SAMPLE_W-1:0] client_mult_a,
    input  logic [N_CLIENTS*SAMPLE_W-1:0] client_mult_b,
    input  logic [N_CLIENTS*DIV_W-1:0]    client_div_n,
    input  logic [N_CLIENTS*DIV_W-1:0]    client_div_d,
    output logic [SAMPLE_W-1:0]           mult_a,
    output logic [SAMPLE_W-1:0]           mult_b,
    output logic [DIV_W-1:0]              div_n,
    output logic [DIV_W-1:0]              div_d
);

    localparam int WDW = $clog2(TIMEOUT) + 1;

    // One extra index bit so idx can step one past the last client and signal the end of the chain.
    state_e               state_q, state_d;
    logic [IDXW:0]        idx_q, idx_d;
    logic [IDXW-1:0]      idx_lo;
    logic [WDW-1:0]       wd_q, wd_d;
    logic [SAMPLE_W-1:0]  chain_q, chain_d;
    logic [SAMPLE_W-1:0]  y_out_q, y_out_d;
    logic                 overrun_q, overrun_d;
    logic                 fault_q, fault_d;

    assign idx_lo = idx_q[IDXW-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            wd_q      <= '0;
            chain_q   <= '0;
            y_out_q   <= '0;
            overrun_q <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            state_q   <= state_d;
            idx_q     <= idx_d;
            wd_q      <= wd_d;
            chain_q   <= chain_d;
            y_out_q   <= y_out_d;
            overrun_q <= overrun_d;
            fault_q   <= fault_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        wd_d      = wd_q;
        chain_d   = chain_q;
        y_out_d   = y_out_q;
        overrun_d = overrun_q;
        fault_d   = fault_q;

        if (sample_tick && state_q != ST_IDLE) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (sample_tick) begin
                    chain_d = x_in;
                    idx_d   = '0;
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                if (int'(idx_q) >= N_CLIENTS) begin
                    y_out_d = chain_q;
                    state_d = ST_DONE;
                end else if (!enable[idx_lo]) begin
                    idx_d = idx_q + (IDXW+1)'(1);
                end else begin
                    wd_d    = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // A finish on the expiry cycle still counts as a normal completion.
                if (client_finish[idx_lo]) begin
                    chain_d = client_y[int'(idx_lo)*SAMPLE_W +: SAMPLE_W];
                    idx_d   = idx_q + (IDXW+1)'(1);
                    state_d = ST_GAP;
                end else if (wd_q == WDW'(TIMEOUT - 1)) begin
                    fault_d = 1'b1;
                    idx_d   = idx_q + (IDXW+1)'(1);
                    state_d = ST_GAP;
                end else begin
                    wd_d = wd_q + WDW'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign y_out        = y_out_q;
    assign y_valid      = (state_q == ST_DONE);
    assign busy         = (state_q != ST_IDLE);
    assign overrun      = overrun_q;
    assign fault        = fault_q;
    assign client_x     = chain_q;
    assign client_start = (state_q == ST_RUN) ? (N_CLIENTS'(1) << idx_lo) : '0;

    dsp_bus_mux #(
        .N_CLIENTS (N_CLIENTS),
        .IDXW      (IDXW)
    ) u_bus_mux (
        .grant_i  (state_q == ST_RUN),
        .idx_i    (idx_lo),
        .mult_a_i (client_mult_a),
        .mult_b_i (client_mult_b),
        .div_n_i  (client_div_n),
        .div_d_i  (client_div_d),
        .mult_a_o (mult_a),
        .mult_b_o (mult_b),
        .div_n_o  (div_n),
        .div_d_o  (div_d)
    );

endmodule

// File: tb/tb_dsp_chain_sched.sv
// Bench for dsp_chain_sched: stub clients with programmable run lengths, checked against a per-sample chain model.
module tb_dsp_chain_sched;
    import dsp_pkg::*;

    localparam int N  = 4;
    localparam int TO = 50;
    localparam int IW = 3;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b1;
    logic                  sample_tick = 1'b0;
    logic [SAMPLE_W-1:0]   x_in = '0;
    logic [N-1:0]          enable = '1;
    logic [SAMPLE_W-1:0]   y_out;
    logic                  y_valid, busy, overrun, fault;
    logic [N-1:0]          client_start, client_finish;
    logic [SAMPLE_W-1:0]   client_x;
    logic [N*SAMPLE_W-1:0] client_y, client_mult_a, client_mult_b;
    logic [N*DIV_W-1:0]    client_div_n, client_div_d;
    logic [SAMPLE_W-1:0]   mult_a, mult_b;
    logic [DIV_W-1:0]      div_n, div_d;

    dsp_chain_sched #(.N_CLIENTS(N), .TIMEOUT(TO), .IDXW(IW)) dut (
        .clk(clk), .rst_n(rst_n), .sample_tick(sample_tick), .x_in(x_in), .enable(enable),
        .y_out(y_out), .y_valid(y_valid), .busy(busy), .overrun(overrun), .fault(fault),
        .client_start(client_start), .client_finish(client_finish), .client_x(client_x),
        .client_y(client_y), .client_mult_a(client_mult_a), .client_mult_b(client_mult_b),
        .client_div_n(client_div_n), .client_div_d(client_div_d),
        .mult_a(mult_a), .mult_b(mult_b), .div_n(div_n), .div_d(div_d)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input longint obs, input longint exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Stub clients: client i answers x+(i+1) on the len[i]-th start cycle (len 0 = never answers),
    // and raises stray finishes while not granted.
    int       len[N];
    int       cnt[N];
    logic [N-1:0] noise = '0;

    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            cnt[i] <= client_start[i] ? cnt[i] + 1 : 0;
            client_mult_a[i*SAMPLE_W +: SAMPLE_W] <= $urandom;
            client_mult_b[i*SAMPLE_W +: SAMPLE_W] <= $urandom;
            client_div_n[i*DIV_W +: DIV_W]        <= {16'($urandom), $urandom};
            client_div_d[i*DIV_W +: DIV_W]        <= {16'($urandom), $urandom};
        end
        noise <= N'($urandom);
    end

    always_comb begin
        client_y      = '0;
        client_finish = '0;
        for (int i = 0; i < N; i++) begin
            client_y[i*SAMPLE_W +: SAMPLE_W] = client_x + SAMPLE_W'(i + 1);
            client_finish[i] = client_start[i] ? (len[i] != 0 && cnt[i] == len[i] - 1) : noise[i];
        end
    end

    // Handshake and bus monitor.
    bit           mon_en = 1'b0;
    logic [N-1:0] prev_start = '0;
    logic [N-1:0] started = '0;
    int           vcount = 0;

    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            logic [SAMPLE_W-1:0] ea, eb;
            logic [DIV_W-1:0]    en_, ed;
            ea = '0; eb = '0; en_ = '0; ed = '0;
            for (int i = 0; i < N; i++) begin
                if (client_start[i]) begin
                    ea  = client_mult_a[i*SAMPLE_W +: SAMPLE_W];
                    eb  = client_mult_b[i*SAMPLE_W +: SAMPLE_W];
                    en_ = client_div_n[i*DIV_W +: DIV_W];
                    ed  = client_div_d[i*DIV_W +: DIV_W];
                end
            end
            check("start_onehot0", longint'($onehot0(client_start)), 1);
            if (prev_start != '0 && client_start != '0)
                check("start_no_overlap", longint'(client_start), longint'(prev_start));
            check("bus_mult_a", longint'(mult_a), longint'(ea));
            check("bus_mult_b", longint'(mult_b), longint'(eb));
            check("bus_div_n", longint'(div_n), longint'(en_));
            check("bus_div_d", longint'(div_d), longint'(ed));
            started    = started | client_start;
            prev_start = client_start;
            if (y_valid) vcount++;
        end else begin
            prev_start = '0;
        end
    end

    bit overrun_model = 1'b0;
    bit fault_model   = 1'b0;

    task automatic pulse_tick(input logic [SAMPLE_W-1:0] x);
        @(posedge clk); #1 sample_tick = 1'b1; x_in = x;
        @(posedge clk); #1 sample_tick = 1'b0; x_in = $urandom;
    endtask

    // One sample through the chain; second_at > 0 injects an extra tick that many cycles after the first.
    task automatic run_sample(input string tag, input logic signed [SAMPLE_W-1:0] x,
                              input logic [N-1:0] en, input int second_at);
        logic signed [SAMPLE_W-1:0] ey;
        int  elat, cyc, v0;
        bit  ef;
        ey = x; elat = 2; ef = fault_model;
        for (int i = 0; i < N; i++) begin
            elat++;
            if (en[i]) begin
                if (len[i] == 0 || len[i] > TO) begin
                    elat += TO;
                    ef = 1'b1;
                end else begin
                    elat += len[i];
                    ey += SAMPLE_W'(i + 1);
                end
            end
        end
        enable = en;
        started = '0;
        v0 = vcount;
        pulse_tick(x);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (second_at != 0) begin
                if (cyc == second_at) begin
                    sample_tick = 1'b1;
                    x_in = $urandom;
                    overrun_model = 1'b1;
                end else begin
                    sample_tick = 1'b0;
                end
            end
        end while (!y_valid && cyc < 1000);
        check({tag, "_latency"}, cyc, elat);
        check({tag, "_y_out"}, longint'($signed(y_out)), longint'(ey));
        check({tag, "_fault"}, longint'(fault), longint'(ef));
        @(negedge clk);
        check({tag, "_busy_after"}, longint'(busy), 0);
        check({tag, "_valid_pulse"}, longint'(y_valid), 0);
        check({tag, "_started"}, longint'(started), longint'(en));
        check({tag, "_overrun"}, longint'(overrun), longint'(overrun_model));
        check({tag, "_valid_count"}, vcount - v0, 1);
        fault_model = ef;
    endtask

    initial begin
        logic signed [23:0] r24;
        int wcyc;
        for (int i = 0; i < N; i++) len[i] = 5;

        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_y_out", longint'(y_out), 0);
        check("rst_y_valid", longint'(y_valid), 0);
        check("rst_busy", longint'(busy), 0);
        check("rst_overrun", longint'(overrun), 0);
        check("rst_fault", longint'(fault), 0);
        check("rst_start", longint'(client_start), 0);
        check("rst_mult_a", longint'(mult_a), 0);
        check("rst_div_n", longint'(div_n), 0);
        rst_n = 1'b1;
        mon_en = 1'b1;
        repeat (2) @(negedge clk);

        run_sample("all_en", 32'sd100, 4'b1111, 0);
        run_sample("en_0101", -32'sd1048576, 4'b0101, 0);
        run_sample("all_dis", 32'sd5555, 4'b0000, 0);

        len[2] = 0;
        run_sample("timeout", 32'sd7, 4'b1111, 0);
        len[2] = TO;
        run_sample("finish_at_expiry", -32'sd9, 4'b1111, 0);
        len[2] = 5;

        run_sample("overrun", 32'sd321, 4'b1111, 3);

        started = '0;
        pulse_tick(32'sd123);
        wcyc = 0;
        while (client_start != 4'b0010 && wcyc < 100) begin
            @(negedge clk);
            wcyc++;
        end
        check("reach_client1", longint'(client_start), 4'b0010);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_start", longint'(client_start), 0);
        check("abort_mult_a", longint'(mult_a), 0);
        check("abort_mult_b", longint'(mult_b), 0);
        check("abort_div_d", longint'(div_d), 0);
        check("abort_busy", longint'(busy), 0);
        check("abort_overrun", longint'(overrun), 0);
        check("abort_fault", longint'(fault), 0);
        check("abort_y_out", longint'(y_out), 0);
        check("abort_client_x", longint'(client_x), 0);
        overrun_model = 1'b0;
        fault_model = 1'b0;
        wcyc = vcount;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        check("abort_no_valid", vcount - wcyc, 0);
        run_sample("after_reset", 32'sd77, 4'b1111, 0);

        for (int k = 0; k < 20; k++) begin
            for (int i = 0; i < N; i++)
                len[i] = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 8));
            r24 = 24'($urandom);
            run_sample("random", SAMPLE_W'(r24), N'($urandom), 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
